stream_xbar_buf: RTL and testbench

STREAM_XBAR_BUF -- requirements
Module: stream_xbar_buf

---
 rtl/stream_xbar_pkg.sv | 28 ++
 rtl/stream_fifo.sv | 55 +++++
 rtl/stream_xbar_buf.sv | 165 ++++++++++++++++
 tb/tb_stream_xbar_buf.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_xbar_pkg.sv
// Shared constants and helpers for the buffered stream crossbar.
// Holds arbitration mode codes and the rotating priority pick.
package stream_xbar_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;
  localparam int MAX_SRC   = 32;

  // Index of the first set request at or after start, wrapping at n;
  // -1 when nothing requests.
  function automatic int rr_select(
    input logic [MAX_SRC-1:0] req,
    input int                 start,
    input int                 n
  );
    int idx;
    int pick;
    pick = -1;
    for (int i = 0; i < MAX_SRC; i++) begin
      idx = (start + i) % n;
      if (i < n && pick < 0 && req[idx[4:0]]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty.
// Ports: push_i/wdata_i/full_o in, pop_i/rdata_o/empty_o out.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);

  // Full refuses a push even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/stream_xbar_buf.sv
// Packet-locking stream crossbar with one arbiter and FIFO per output.
// Ports: s_* input streams, m_* buffered outputs, err_dest_o bad-dest pulse.
module stream_xbar_buf
  import stream_xbar_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int ARB_MODE     = 0,
  localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                   s_last_i,
  input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
  output logic [S_DATA_COUNT-1:0]                   s_ready_o,
  output logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o,
  output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] m_id_o,
  output logic [M_DATA_COUNT-1:0]                   m_last_o,
  output logic [M_DATA_COUNT-1:0]                   m_valid_o,
  input  logic [M_DATA_COUNT-1:0]                   m_ready_i,
  output logic [S_DATA_COUNT-1:0]                   err_dest_o
);

  localparam int EW = T_DATA_WIDTH + T_ID___WIDTH + 1;
  localparam logic [T_DEST_WIDTH:0] M_LIM =
    (T_DEST_WIDTH+1)'(M_DATA_COUNT);

  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req;
  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] gnt;
  logic [M_DATA_COUNT-1:0]                   push;
  logic [M_DATA_COUNT-1:0]                   pop;
  logic [M_DATA_COUNT-1:0]                   full;
  logic [M_DATA_COUNT-1:0]                   empty;
  logic [M_DATA_COUNT-1:0][EW-1:0]           wdata;
  logic [M_DATA_COUNT-1:0][EW-1:0]           rdata;
  logic [S_DATA_COUNT-1:0]                   bad;

  logic [M_DATA_COUNT-1:0]                   lock_q, lock_d;
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] owner_q, owner_d;
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] rr_q, rr_d;
  logic [S_DATA_COUNT-1:0]                   slock_q, slock_d;
  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] sdest_q, sdest_d;

  int pick;
  int start_v;

  always_comb begin
    lock_d     = lock_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    slock_d    = slock_q;
    sdest_d    = sdest_q;
    req        = '0;
    gnt        = '0;
    push       = '0;
    wdata      = '0;
    bad        = '0;
    s_ready_o  = '0;
    err_dest_o = '0;
    pick       = -1;
    start_v    = 0;

    for (int s = 0; s < S_DATA_COUNT; s++) begin
      bad[s] = s_valid_i[s] && !slock_q[s] &&
               ({1'b0, s_dest_i[s]} >= M_LIM);
    end

    // A locked source keeps targeting its packet's output.
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      for (int s = 0; s < S_DATA_COUNT; s++) begin
        req[m][s] = s_valid_i[s] &&
          (slock_q[s] ? (sdest_q[s] == T_DEST_WIDTH'(m))
                      : (s_dest_i[s] == T_DEST_WIDTH'(m)));
      end
    end

    for (int m = 0; m < M_DATA_COUNT; m++) begin
      start_v = (ARB_MODE == ARB_FIXED) ? 0 : int'(rr_q[m]);
      pick    = rr_select(MAX_SRC'(req[m]), start_v, S_DATA_COUNT);
      for (int s = 0; s < S_DATA_COUNT; s++) begin
        gnt[m][s] = lock_q[m]
          ? (req[m][s] && owner_q[m] == T_ID___WIDTH'(s))
          : (pick == s);
      end

      if (!full[m]) begin
        for (int s = 0; s < S_DATA_COUNT; s++) begin
          if (gnt[m][s]) begin
            push[m]      = 1'b1;
            s_ready_o[s] = 1'b1;
            wdata[m]     = {s_data_i[s], T_ID___WIDTH'(s), s_last_i[s]};
            if (s_last_i[s]) begin
              lock_d[m]  = 1'b0;
              slock_d[s] = 1'b0;
              rr_d[m]    = T_ID___WIDTH'((s + 1) % S_DATA_COUNT);
            end else begin
              lock_d[m]  = 1'b1;
              owner_d[m] = T_ID___WIDTH'(s);
              slock_d[s] = 1'b1;
              sdest_d[s] = T_DEST_WIDTH'(m);
            end
          end
        end
      end
    end

    // Out-of-range beats are swallowed and flagged.
    for (int s = 0; s < S_DATA_COUNT; s++) begin
      if (bad[s]) begin
        s_ready_o[s]  = 1'b1;
        err_dest_o[s] = 1'b1;
      end
    end

    if (!rst_n) begin
      s_ready_o  = '0;
      err_dest_o = '0;
      push       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      slock_q <= '0;
      sdest_q <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      slock_q <= slock_d;
      sdest_q <= sdest_d;
    end
  end

  for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_out
    stream_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[m]),
      .wdata_i (wdata[m]),
      .full_o  (full[m]),
      .pop_i   (pop[m]),
      .empty_o (empty[m]),
      .rdata_o (rdata[m])
    );

    assign pop[m]       = m_ready_i[m] && !empty[m];
    assign m_valid_o[m] = !empty[m];
    assign m_data_o[m]  = rdata[m][EW-1 -: T_DATA_WIDTH];
    assign m_id_o[m]    = rdata[m][T_ID___WIDTH:1];
    assign m_last_o[m]  = !empty[m] && rdata[m][0];
  end

endmodule

// File: tb/tb_stream_xbar_buf.sv
// Directed bench for stream_xbar_buf: vector table plus corner sequences.
// A second instance runs fixed-priority arbitration.
module tb_stream_xbar_buf;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0][7:0]  s_data;
  logic [1:0][1:0]  s_dest;
  logic [1:0]       s_last;
  logic [1:0]       s_valid;
  logic [1:0]       s_ready;
  logic [2:0][7:0]  m_data;
  logic [2:0][0:0]  m_id;
  logic [2:0]       m_last;
  logic [2:0]       m_valid;
  logic [2:0]       m_ready;
  logic [1:0]       err_dest;

  logic [1:0]       f_s_ready;
  logic [2:0][7:0]  f_m_data;
  logic [2:0][0:0]  f_m_id;
  logic [2:0]       f_m_last;
  logic [2:0]       f_m_valid;
  logic [1:0]       f_err;

  int errors = 0;
  int checks = 0;

  logic [8:0] mq1[$];
  logic [8:0] mq2[$];

  always #5 clk = ~clk;

  stream_xbar_buf u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data_i   (s_data),
    .s_dest_i   (s_dest),
    .s_last_i   (s_last),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .m_data_o   (m_data),
    .m_id_o     (m_id),
    .m_last_o   (m_last),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .err_dest_o (err_dest)
  );

  stream_xbar_buf #(.ARB_MODE(1)) u_fix (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data_i   (s_data),
    .s_dest_i   (s_dest),
    .s_last_i   (s_last),
    .s_valid_i  (s_valid),
    .s_ready_o  (f_s_ready),
    .m_data_o   (f_m_data),
    .m_id_o     (f_m_id),
    .m_last_o   (f_m_last),
    .m_valid_o  (f_m_valid),
    .m_ready_i  (m_ready),
    .err_dest_o (f_err)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid[1] && m_ready[1]) mq1.push_back({m_id[1], m_data[1]});
      if (m_valid[2] && m_ready[2]) mq2.push_back({m_id[2], m_data[2]});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    s_valid = 2'b11;
    s_dest[0] = 2'd3;
    s_dest[1] = 2'd3;
    s_last = 2'b11;
    m_ready = 3'b111;
    rst_n = 1'b0;
    #1;
    chk("rst_mvalid", 32'(m_valid), 32'(0));
    chk("rst_mlast", 32'(m_last), 32'(0));
    chk("rst_err", 32'(err_dest), 32'(0));
    chk("rst_f_mvalid", 32'(f_m_valid), 32'(0));
    s_valid = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc();
    mq1.delete();
    mq2.delete();
  endtask

  typedef struct {
    logic [1:0] vld;
    logic [1:0] d0;
    logic [1:0] d1;
    logic [1:0] e_rdy;
    logic [1:0] e_err;
    logic [2:0] e_mv;
    logic       e_id0;
  } vec_t;

  vec_t tbl[7];
  logic [8:0] exp2[4];
  int n;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    s_data  = '0;
    s_dest  = '0;
    s_last  = '0;
    s_valid = '0;
    m_ready = '0;

    // Alternating single beats, then a bad destination.
    tbl[0] = '{2'b11, 2'd0, 2'd0, 2'b01, 2'b00, 3'b000, 1'b0};
    tbl[1] = '{2'b11, 2'd0, 2'd0, 2'b10, 2'b00, 3'b001, 1'b0};
    tbl[2] = '{2'b11, 2'd0, 2'd0, 2'b01, 2'b00, 3'b001, 1'b1};
    tbl[3] = '{2'b11, 2'd0, 2'd0, 2'b10, 2'b00, 3'b001, 1'b0};
    tbl[4] = '{2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 3'b001, 1'b1};
    tbl[5] = '{2'b01, 2'd3, 2'd0, 2'b01, 2'b01, 3'b000, 1'b0};
    tbl[6] = '{2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 3'b000, 1'b0};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      s_valid   = tbl[i].vld;
      s_dest[0] = tbl[i].d0;
      s_dest[1] = tbl[i].d1;
      s_last    = 2'b11;
      s_data[0] = 8'h01;
      s_data[1] = 8'h02;
      m_ready   = 3'b111;
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i), 32'(s_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_err", i), 32'(err_dest), 32'(tbl[i].e_err));
      chk($sformatf("v%0d_mv", i), 32'(m_valid), 32'(tbl[i].e_mv));
      if (tbl[i].e_mv[0]) begin
        chk($sformatf("v%0d_id", i), 32'(m_id[0]), 32'(tbl[i].e_id0));
      end
      cyc();
    end

    // Locked 3-beat packet versus a waiting single beat.
    do_reset();
    exp2[0] = 9'h010;
    exp2[1] = 9'h011;
    exp2[2] = 9'h012;
    exp2[3] = 9'h120;
    s_valid = 2'b11;
    s_dest[0] = 2'd2;
    s_dest[1] = 2'd2;
    s_last = 2'b10;
    s_data[0] = 8'h10;
    s_data[1] = 8'h20;
    m_ready = 3'b111;
    for (int b = 0; b < 3; b++) begin
      s_data[0] = 8'(8'h10 + b);
      s_last[0] = (b == 2);
      @(negedge clk);
      chk($sformatf("lock_rdy%0d", b), 32'(s_ready), 32'(2'b01));
      cyc();
    end
    s_valid = 2'b10;
    @(negedge clk);
    chk("lock_rdy_src1", 32'(s_ready), 32'(2'b10));
    cyc();
    s_valid = 2'b00;
    repeat (4) cyc();
    chk("lock_cnt", 32'(mq2.size()), 32'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < mq2.size()) chk($sformatf("lock_beat%0d", k), 32'(mq2[k]), 32'(exp2[k]));
    end

    // Backpressure to a full FIFO, then drain.
    do_reset();
    s_valid = 2'b01;
    s_dest[0] = 2'd1;
    s_last = 2'b00;
    m_ready = 3'b101;
    for (int i = 0; i < 4; i++) begin
      s_data[0] = 8'(8'hA0 + i);
      @(negedge clk);
      chk($sformatf("fill_rdy%0d", i), 32'(s_ready[0]), 32'(1));
      cyc();
    end
    s_data[0] = 8'hA4;
    @(negedge clk);
    chk("full_rdy", 32'(s_ready[0]), 32'(0));
    chk("full_mv1", 32'(m_valid[1]), 32'(1));
    chk("full_head", 32'(m_data[1]), 32'(8'hA0));
    cyc();
    m_ready = 3'b111;
    @(negedge clk);
    chk("full_pop_rdy", 32'(s_ready[0]), 32'(0));
    cyc();
    n = 4;
    for (int c = 0; c < 20 && n < 6; c++) begin
      s_data[0] = 8'(8'hA0 + n);
      s_last[0] = (n == 5);
      @(negedge clk);
      if (s_ready[0]) n++;
      cyc();
    end
    s_valid = 2'b00;
    chk("stream_done", 32'(n), 32'(6));
    repeat (8) cyc();
    chk("drain_cnt", 32'(mq1.size()), 32'(6));
    for (int k = 0; k < 6; k++) begin
      if (k < mq1.size()) chk($sformatf("drain%0d", k), 32'(mq1[k]), 32'(8'hA0 + k));
    end

    // Reset in the middle of a locked packet.
    do_reset();
    s_valid = 2'b11;
    s_dest[0] = 2'd0;
    s_dest[1] = 2'd0;
    s_last = 2'b10;
    s_data[0] = 8'hC0;
    s_data[1] = 8'hD0;
    m_ready = 3'b110;
    @(negedge clk);
    chk("mid_rdy0", 32'(s_ready), 32'(2'b01));
    cyc();
    s_data[0] = 8'hC1;
    @(negedge clk);
    chk("mid_rdy1", 32'(s_ready), 32'(2'b01));
    chk("mid_mv", 32'(m_valid[0]), 32'(1));
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mv", 32'(m_valid), 32'(0));
    chk("mid_rst_rdy", 32'(s_ready), 32'(0));
    s_dest[0] = 2'd1;
    s_data[0] = 8'hC2;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy", 32'(s_ready), 32'(2'b11));
    cyc();
    s_valid = 2'b00;
    chk("post_mv", 32'(m_valid), 32'(3'b011));
    chk("post_id0", 32'(m_id[0]), 32'(1));
    chk("post_data0", 32'(m_data[0]), 32'(8'hD0));
    chk("post_id1", 32'(m_id[1]), 32'(0));
    repeat (2) cyc();

    // Fixed priority: source 0 always wins.
    do_reset();
    s_valid = 2'b11;
    s_dest[0] = 2'd0;
    s_dest[1] = 2'd0;
    s_last = 2'b11;
    m_ready = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("fix_rdy%0d", i), 32'(f_s_ready), 32'(2'b01));
      if (i > 0) begin
        chk($sformatf("fix_mv%0d", i), 32'(f_m_valid[0]), 32'(1));
        chk($sformatf("fix_id%0d", i), 32'(f_m_id[0]), 32'(0));
      end
      cyc();
    end
    s_valid = 2'b00;
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
